alu_seq_ctrl: RTL and testbench

Multi-cycle operation sequencer that drives the single-cycle 32-bit ALU (`alu`) to perform operations the ALU cannot do in one pass. It supports logical shift-left by N, logical shift-right by N and an unsigned 32×32 multiply returning the low 32 bits. Shifts are built from repeated shift-by-1 passes; the multiply uses shift-and-add. It sits beside the EX stage, owns the ALU's a/b/sel inputs while busy, and returns a registered result with a done pulse.

---
 rtl/alu_seq_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle sequencer driving a single-cycle ALU to perform
// logical shift-left/right by N (repeated shift-by-1) and, when
// ALU_SEQ_MUL_EN is defined, an unsigned shift-and-add multiply (low WIDTH bits).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, op, opa, opb      request strobe, operation (00 SLL, 01 SRL, 10 MUL, 11 rsvd), operands
//   busy, done               sequencing flag, one-cycle result-valid pulse
//   result, zero             registered result and (result == 0)
//   alu_a, alu_b, alu_sel    ALU operands/select owned by this block
//   alu_c                    ALU combinational result, consumed the same cycle
//
// Configuration macro: ALU_SEQ_MUL_EN (undefined: op 10 behaves as reserved).
module alu_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_c
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;

    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_SHL1 = 3'b100;
    localparam logic [2:0] SEL_SHR1 = 3'b110;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SHIFT = 3'd1;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state,   state_nxt;
    logic [1:0]       op_q,    op_nxt;
    logic [WIDTH-1:0] work,    work_nxt;
    logic [CNT_W-1:0] count,   count_nxt;
    logic [WIDTH-1:0] result_nxt;
    logic [WIDTH-1:0] alu_a_nxt, alu_b_nxt;
    logic [2:0]       alu_sel_nxt;
    logic             accept_c;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [2:0] S_MADD = 3'd2;
    localparam logic [2:0] S_MSHL = 3'd3;

    logic [WIDTH-1:0] acc,    acc_nxt;
    logic [WIDTH-1:0] mcand,  mcand_nxt;
    logic [WIDTH-1:0] mplier, mplier_nxt;
    logic             mul_branch_c;
`else
    // Multiplier bits above the shift amount are only meaningful for MUL.
    logic unused_opb_hi;
    assign unused_opb_hi = ^opb[WIDTH-1:CNT_W];
`endif

    assign accept_c = start && ((state == S_IDLE) || (state == S_DONE));

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_nxt   = state;
        op_nxt      = op_q;
        work_nxt    = work;
        count_nxt   = count;
        result_nxt  = result;
        alu_a_nxt   = '0;
        alu_b_nxt   = '0;
        alu_sel_nxt = SEL_ADD;
`ifdef ALU_SEQ_MUL_EN
        acc_nxt      = acc;
        mcand_nxt    = mcand;
        mplier_nxt   = mplier;
        mul_branch_c = 1'b0;
`endif

        case (state)
            S_SHIFT: begin
                work_nxt  = alu_c;
                count_nxt = count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state_nxt  = S_DONE;
                    result_nxt = alu_c;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MADD: begin
                acc_nxt   = alu_c;
                state_nxt = S_MSHL;
            end
            S_MSHL: begin
                mcand_nxt    = alu_c;
                mplier_nxt   = mplier >> 1;
                mul_branch_c = 1'b1;
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = state;
        endcase

        if (accept_c) begin
            op_nxt    = op;
            work_nxt  = opa;
            count_nxt = opb[CNT_W-1:0];
`ifdef ALU_SEQ_MUL_EN
            acc_nxt    = '0;
            mcand_nxt  = opa;
            mplier_nxt = opb;
`endif
            if ((op == OP_SLL) || (op == OP_SRL)) begin
                if (opb[CNT_W-1:0] == '0) begin
                    state_nxt  = S_DONE;
                    result_nxt = opa;
                end else begin
                    state_nxt = S_SHIFT;
                end
`ifdef ALU_SEQ_MUL_EN
            end else if (op == OP_MUL) begin
                mul_branch_c = 1'b1;
`endif
            end else begin
                state_nxt  = S_DONE;
                result_nxt = opa;
            end
        end

`ifdef ALU_SEQ_MUL_EN
        // Iteration branch, evaluated on the freshly updated multiplier
        if (mul_branch_c) begin
            if (mplier_nxt == '0) begin
                state_nxt  = S_DONE;
                result_nxt = acc_nxt;
            end else if (mplier_nxt[0]) begin
                state_nxt = S_MADD;
            end else begin
                state_nxt = S_MSHL;
            end
        end
`endif

        // ALU drive for the state being entered, so the pins are registered
        case (state_nxt)
            S_SHIFT: begin
                alu_a_nxt   = work_nxt;
                alu_sel_nxt = (op_nxt == OP_SRL) ? SEL_SHR1 : SEL_SHL1;
            end
`ifdef ALU_SEQ_MUL_EN
            S_MADD: begin
                alu_a_nxt   = acc_nxt;
                alu_b_nxt   = mcand_nxt;
                alu_sel_nxt = SEL_ADD;
            end
            S_MSHL: begin
                alu_a_nxt   = mcand_nxt;
                alu_sel_nxt = SEL_SHL1;
            end
`endif
            default: alu_sel_nxt = SEL_ADD;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= '0;
            work    <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= SEL_ADD;
`ifdef ALU_SEQ_MUL_EN
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
`endif
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            work    <= work_nxt;
            count   <= count_nxt;
            busy    <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done    <= (state_nxt == S_DONE);
            result  <= result_nxt;
            zero    <= (result_nxt == '0);
            alu_a   <= alu_a_nxt;
            alu_b   <= alu_b_nxt;
            alu_sel <= alu_sel_nxt;
`ifdef ALU_SEQ_MUL_EN
            acc     <= acc_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, hand-written
// multi-cycle sequences and random operations against a behavioural model.
// Follows ALU_SEQ_MUL_EN: op 10 is expected to behave as reserved when undefined.
module tb_alu_seq_ctrl;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MAX_WAIT = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa, opb;
    logic        busy, done, zero;
    logic [31:0] result, alu_a, alu_b, alu_c;
    logic [2:0]  alu_sel;

    int n_total = 0;
    int n_pass  = 0;

    alu_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c)
    );

    always #5 clk = ~clk;

    // Single-cycle ALU the sequencer drives
    always_comb begin
        case (alu_sel)
            3'b000:  alu_c = alu_a + alu_b;
            3'b100:  alu_c = alu_a << 1;
            3'b110:  alu_c = alu_a >> 1;
            default: alu_c = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int n;
        n = int'(b[4:0]);
        p = 64'(a) * 64'(b);
        case (o)
            2'b00:   return a << n;
            2'b01:   return a >> n;
            2'b10:   return MUL_EN ? p[31:0] : a;
            default: return a;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
        int msb;
        if (o == 2'b00 || o == 2'b01) return int'(b[4:0]) + 1;
        if (o == 2'b10 && MUL_EN && b != 0) begin
            msb = 0;
            for (int i = 0; i < 32; i++) if (b[i]) msb = i;
            return msb + 1 + $countones(b) + 1;
        end
        return 1;
    endfunction

    // Issue one op at a negedge and wait for done; returns at the negedge where done is seen.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat,
                          input int glitch_at);
        int lat;
        logic [2:0] exp_sel;
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        lat = MAX_WAIT + 1;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check({name, ".busy"}, 32'(busy), 32'(exp_lat > 1));
                if (exp_lat > 1) begin
                    if (o == 2'b01)      exp_sel = 3'b110;
                    else if (o == 2'b00) exp_sel = 3'b100;
                    else                 exp_sel = b[0] ? 3'b000 : 3'b100;
                    check({name, ".sel"}, 32'(alu_sel), 32'(exp_sel));
                    if (o != 2'b10) check({name, ".alu_a"}, alu_a, a);
                end
            end
            if (done) begin
                lat = i;
                break;
            end
            if (i == glitch_at) begin
                start = 1'b1; op = 2'b01; opa = 32'h0000_FFFF; opb = 32'd2;
            end else begin
                start = 1'b0; opa = $urandom; opb = $urandom;
            end
        end
        start = 1'b0;
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".result"}, result, exp_res);
        check({name, ".zero"}, 32'(zero), 32'(exp_res == 32'h0));
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        int          done_seen;

        vecs.push_back('{"sll1x31",   2'b00, 32'h0000_0001, 32'd31, 32'h8000_0000, 32});
        vecs.push_back('{"srl8x31",   2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 32});
        vecs.push_back('{"shift0",    2'b00, 32'h1234_5678, 32'd0,  32'h1234_5678, 1});
        vecs.push_back('{"sll_by32",  2'b00, 32'hFFFF_FFFF, 32'd32, 32'hFFFF_FFFF, 1});
        vecs.push_back('{"srl_by4",   2'b01, 32'hF0F0_F0F0, 32'd4,  32'h0F0F_0F0F, 5});
        vecs.push_back('{"sll_out",   2'b00, 32'h8000_0000, 32'd1,  32'h0000_0000, 2});
        vecs.push_back('{"rsvd",      2'b11, 32'hDEAD_BEEF, 32'd7,  32'hDEAD_BEEF, 1});
`ifdef ALU_SEQ_MUL_EN
        vecs.push_back('{"mul3x5",    2'b10, 32'd3,         32'd5,  32'd15,        6});
        vecs.push_back('{"mul_by0",   2'b10, 32'h1234_5678, 32'd0,  32'h0,         1});
        vecs.push_back('{"mul_max",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,  65});
`else
        vecs.push_back('{"mul3x5",    2'b10, 32'd3,         32'd5,  32'd3,         1});
        vecs.push_back('{"mul_by0",   2'b10, 32'h1234_5678, 32'd0,  32'h1234_5678, 1});
        vecs.push_back('{"mul_max",   2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1});
`endif

        rst = 1'b1; start = 1'b0; op = 2'b00; opa = 32'h0; opb = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.busy",   32'(busy),    32'h0);
        check("rst.done",   32'(done),    32'h0);
        check("rst.result", result,       32'h0);
        check("rst.zero",   32'(zero),    32'h1);
        check("rst.sel",    32'(alu_sel), 32'h0);
        check("rst.alu_a",  alu_a,        32'h0);
        check("rst.alu_b",  alu_b,        32'h0);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 0);
            @(negedge clk);
        end

        // Done is a single pulse and the result holds through idle
        run_op("hold", 2'b00, 32'h0000_0003, 32'd3, 32'h0000_0018, 4, 0);
        @(negedge clk);
        check("hold.done1",  32'(done), 32'h0);
        check("hold.busy1",  32'(busy), 32'h0);
        @(negedge clk);
        check("hold.result", result,    32'h0000_0018);

        // Start while busy is ignored
        run_op("glitch", 2'b00, 32'h0000_0001, 32'd8, 32'h0000_0100, 9, 3);
        @(negedge clk);

        // Back-to-back: new start in the DONE cycle, no idle bubble
        run_op("b2b_a", 2'b00, 32'h0000_0003, 32'd2, 32'h0000_000C, 3, 0);
        run_op("b2b_b", 2'b01, 32'h0000_0080, 32'd3, 32'h0000_0010, 4, 0);
        run_op("b2b_c", 2'b00, 32'h0000_0000, 32'd0, 32'h0000_0000, 1, 0);
        run_op("b2b_d", 2'b11, 32'h0000_0055, 32'd0, 32'h0000_0055, 1, 0);
        @(negedge clk);

        // Reset mid-operation aborts without a done
        start = 1'b1; opa = 32'hFFFF_FFFF;
        op  = MUL_EN ? 2'b10 : 2'b00;
        opb = MUL_EN ? 32'hFFFF_FFFF : 32'd31;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort.busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy",   32'(busy),    32'h0);
        check("abort.done",   32'(done),    32'h0);
        check("abort.result", result,       32'h0);
        check("abort.zero",   32'(zero),    32'h1);
        check("abort.sel",    32'(alu_sel), 32'h0);
        check("abort.alu_a",  alu_a,        32'h0);
        check("abort.alu_b",  alu_b,        32'h0);
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort.no_done", 32'(done_seen), 32'h0);
        run_op("post_rst", 2'b00, 32'h0000_0001, 32'd4, 32'h0000_0010, 5, 0);
        @(negedge clk);

        // Random operations against the behavioural model
        for (int k = 0; k < 40; k++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = (r_op == 2'b10 && $urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) : $urandom;
            run_op($sformatf("rnd%0d", k), r_op, r_a, r_b, model_result(r_op, r_a, r_b),
                   model_lat(r_op, r_b), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
